// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART link: receiver state encoding,
// frame data width and the line idle level.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Serial line level when no frame is in flight (also the stop-bit level).
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to the line idle level so that leaving reset never looks like a start edge.
// Only built when UART_RX_SYNC_EN is defined; uart_rx instantiates it only
// in that configuration.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the pad-side line into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= LINE_IDLE;
            q    <= LINE_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the line on the shared baud tick (enable),
// qualifies the start bit at its midpoint, samples data and stop bits at
// their centres, and reports each good byte with a one-clk valid strobe.
// A bad stop bit sets a sticky framing error and parks in BREAK until the
// line returns high.
// Optional: define UART_RX_SYNC_EN to pass rx_in through a two-flop
// synchroniser (needed when rx_in comes straight from a pad).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       error
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end

    if (DATA_BITS != 8) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS is fixed at 8");
    end

    uart_rx_state_t state;
    logic [TW-1:0]  tick_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_in),
        .q       (rx_s)
    );
`else
    assign rx_s = rx_in;
`endif

    // A frame is in progress whenever the receiver is not idle.
    assign busy = (state != IDLE);

    // Frame state machine; every transition is gated by the oversample tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (rx_s == 1'b0) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == MID_TICK) begin
                            tick_cnt <= '0;
                            if (rx_s == 1'b0) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            shift[bit_cnt] <= rx_s;
                            tick_cnt       <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            if (rx_s == LINE_IDLE) begin
                                data_out <= shift;
                                valid    <= 1'b1;
                                error    <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                error <= 1'b1;
                                state <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rx_s == LINE_IDLE) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: OVERSAMPLE=16, enable every 4th clk,
// so one bit period is 64 clk. Expected bytes are queued as frames are
// driven and popped when the receiver strobes valid.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       error;

    logic       en_gate;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    logic       prev_valid;
    int         checks;
    int         failures;

    uart_rx #(
        .OVERSAMPLE (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .rx_in    (rx_in),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clk high every 4 clk, suppressed while en_gate is low.
    initial begin
        enable = 1'b0;
        forever begin
            for (int ph = 0; ph < 4; ph++) begin
                @(posedge clk);
                #2;
                enable = en_gate && (ph == 3);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; gap_bit selects a data bit during which the baud
    // tick pauses for 100 clk (the transmitter stretches that bit to match).
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int gap_bit);
        rx_in = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (i == gap_bit) begin
                wait_clk(20);
                en_gate = 1'b0;
                wait_clk(100);
                en_gate = 1'b1;
                wait_clk(BIT_CLK - 20);
            end else begin
                wait_clk(BIT_CLK);
            end
        end
        rx_in = stop_v;
        wait_clk(BIT_CLK);
    endtask

    // Scoreboard monitor: every valid must match the oldest queued byte,
    // last exactly one clk, and coincide with a cleared error flag.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_valid) chk("valid_width", valid, 1'b0);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", valid, 1'b0);
                end else begin
                    exp_byte = exp_q.pop_front();
                    chk("rx_data", data_out, exp_byte);
                    chk("rx_error_clear", error, 1'b0);
                    chk("busy_at_valid", busy, 1'b0);
                end
            end
        end
        prev_valid = valid;
    end

    initial begin
        checks     = 0;
        failures   = 0;
        prev_valid = 1'b0;
        en_gate    = 1'b1;
        rx_in      = 1'b1;
        reset_n    = 1'b0;
        wait_clk(5);
        chk("reset_data", data_out, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_error", error, 1'b0);
        reset_n = 1'b1;
        wait_clk(BIT_CLK);

        // Good frame with busy observed during the start bit.
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                wait_clk(16);
                chk("busy_in_frame", busy, 1'b1);
            end
        join
        wait_clk(2 * BIT_CLK);
        chk("a5_drained", exp_q.size(), 0);
        chk("a5_idle_busy", busy, 1'b0);

        // Framing error: stop bit low, line held low three bit periods.
        send_frame(8'h3C, 1'b0, -1);
        wait_clk(2 * BIT_CLK);
        chk("ferr_error", error, 1'b1);
        chk("ferr_break_busy", busy, 1'b1);
        chk("ferr_data_kept", data_out, 8'hA5);
        rx_in = 1'b1;
        wait_clk(BIT_CLK);
        chk("ferr_break_exit", busy, 1'b0);
        chk("ferr_error_sticky", error, 1'b1);

        // Glitch: low for 8 ticks only; rejected, error left set.
        rx_in = 1'b0;
        wait_clk(16);
        chk("glitch_busy", busy, 1'b1);
        wait_clk(16);
        rx_in = 1'b1;
        wait_clk(BIT_CLK);
        chk("glitch_idle", busy, 1'b0);
        chk("glitch_error_kept", error, 1'b1);
        chk("glitch_data_kept", data_out, 8'hA5);

        // Good frame after the error clears it.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        wait_clk(BIT_CLK);
        chk("3c_drained", exp_q.size(), 0);
        chk("3c_error_cleared", error, 1'b0);

        // Back-to-back frames with no idle gap.
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, -1);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, -1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        wait_clk(BIT_CLK);
        chk("b2b_drained", exp_q.size(), 0);

        // Baud tick paused for 100 clk in the middle of data bit 3.
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 3);
        wait_clk(BIT_CLK);
        chk("gap_drained", exp_q.size(), 0);
        chk("gap_data_hold", data_out, 8'h81);

        // Set the error again so reset has something to clear.
        send_frame(8'h99, 1'b0, -1);
        rx_in = 1'b1;
        wait_clk(2 * BIT_CLK);
        chk("pre_reset_error", error, 1'b1);

        // Reset in the middle of a frame.
        rx_in = 1'b0;
        wait_clk(BIT_CLK);
        rx_in = 1'b1;
        wait_clk(BIT_CLK);
        rx_in = 1'b0;
        wait_clk(30);
        chk("midframe_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_data", data_out, 8'h00);
        chk("mid_reset_valid", valid, 1'b0);
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_error", error, 1'b0);
        rx_in = 1'b1;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(2 * BIT_CLK);
        chk("post_reset_idle", busy, 1'b0);

        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        wait_clk(2 * BIT_CLK);
        chk("7e_drained", exp_q.size(), 0);
        chk("final_error", error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
